// File: rtl/mii_nibble_tx.sv
// MII transmit framer: turns a valid/ready byte stream into preamble, SFD, payload,
// zero padding and CRC-32 FCS nibbles on txen/txd, then holds an inter-frame gap.
module mii_nibble_tx #(
    parameter int PRE_NIBBLES = 15,
    parameter int MIN_BYTES   = 60,
    parameter int ADD_FCS     = 1,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       txen,
    output logic [3:0] txd,
    output logic       busy,
    output logic       underrun
);

    localparam logic [31:0] POLY = 32'hEDB88320;
    // The single IDLE cycle before a new frame is the final gap nibble.
    localparam int IFG_CYC = (IFG_NIBBLES > 1) ? IFG_NIBBLES - 1 : 1;

    typedef enum logic [2:0] {IDLE, PRE, SFD, DLO, DHI, PAD, FCS, IFG} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  hi_q;
    logic        last_q;
    logic [10:0] bcnt_q;
    logic [31:0] crc_q;
    logic        txen_q;
    logic [3:0]  txd_q;
    logic        und_q;

    logic [31:0] crc_d;
    logic [31:0] fcs_d;
    logic        xfer_pt;
    logic        pad_need;
    logic [15:0] pad_cnt;

    always_comb begin
        crc_d = crc_q ^ {28'd0, txd_q};
        for (int i = 0; i < 4; i++)
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY) : (crc_d >> 1);
        fcs_d    = ~crc_d;
        xfer_pt  = (state_q == SFD) || (state_q == DHI && !last_q);
        pad_need = int'(bcnt_q) < MIN_BYTES;
        pad_cnt  = 16'(2 * (MIN_BYTES - int'(bcnt_q)) - 1);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            last_q  <= 1'b0;
            bcnt_q  <= '0;
            crc_q   <= 32'hFFFFFFFF;
            txen_q  <= 1'b0;
            txd_q   <= '0;
            und_q   <= 1'b0;
        end else begin
            und_q <= 1'b0;
            if (state_q == DLO || state_q == DHI || state_q == PAD)
                crc_q <= crc_d;
            unique case (state_q)
                IDLE: if (s_valid) begin
                    state_q <= PRE;
                    cnt_q   <= 16'(PRE_NIBBLES - 1);
                    crc_q   <= 32'hFFFFFFFF;
                    bcnt_q  <= '0;
                    last_q  <= 1'b0;
                    txen_q  <= 1'b1;
                    txd_q   <= 4'h5;
                end
                PRE: if (cnt_q == 16'd0) begin
                    state_q <= SFD;
                    txd_q   <= 4'hD;
                end else begin
                    cnt_q <= cnt_q - 16'd1;
                end
                SFD, DHI: if (xfer_pt) begin
                    if (s_valid) begin
                        state_q <= DLO;
                        txd_q   <= s_data[3:0];
                        hi_q    <= s_data[7:4];
                        last_q  <= s_last;
                        if (bcnt_q != 11'h7FF) bcnt_q <= bcnt_q + 11'd1;
                    end else begin
                        // Source starved us mid-frame: drop the line, no FCS.
                        state_q <= IFG;
                        cnt_q   <= 16'(IFG_CYC - 1);
                        txen_q  <= 1'b0;
                        txd_q   <= '0;
                        und_q   <= 1'b1;
                    end
                end else if (pad_need) begin
                    state_q <= PAD;
                    cnt_q   <= pad_cnt;
                    txd_q   <= '0;
                end else if (ADD_FCS != 0) begin
                    state_q <= FCS;
                    cnt_q   <= 16'd7;
                    txd_q   <= fcs_d[3:0];
                    crc_q   <= fcs_d >> 4;
                end else begin
                    state_q <= IFG;
                    cnt_q   <= 16'(IFG_CYC - 1);
                    txen_q  <= 1'b0;
                    txd_q   <= '0;
                end
                DLO: begin
                    state_q <= DHI;
                    txd_q   <= hi_q;
                end
                PAD: if (cnt_q != 16'd0) begin
                    cnt_q <= cnt_q - 16'd1;
                end else if (ADD_FCS != 0) begin
                    state_q <= FCS;
                    cnt_q   <= 16'd7;
                    txd_q   <= fcs_d[3:0];
                    crc_q   <= fcs_d >> 4;
                end else begin
                    state_q <= IFG;
                    cnt_q   <= 16'(IFG_CYC - 1);
                    txen_q  <= 1'b0;
                    txd_q   <= '0;
                end
                FCS: if (cnt_q == 16'd0) begin
                    state_q <= IFG;
                    cnt_q   <= 16'(IFG_CYC - 1);
                    txen_q  <= 1'b0;
                    txd_q   <= '0;
                end else begin
                    // crc_q doubles as the FCS shift register here.
                    cnt_q <= cnt_q - 16'd1;
                    txd_q <= crc_q[3:0];
                    crc_q <= crc_q >> 4;
                end
                IFG: if (cnt_q == 16'd0) state_q <= IDLE;
                     else cnt_q <= cnt_q - 16'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready  = xfer_pt;
    assign txen     = txen_q;
    assign txd      = txd_q;
    assign busy     = (state_q != IDLE);
    assign underrun = und_q;

endmodule

// File: tb/tb_mii_nibble_tx.sv
// Directed bench for mii_nibble_tx: table of frames plus back-to-back and reset sequences.
module tb_mii_nibble_tx;

    localparam logic [31:0] POLY = 32'hEDB88320;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sd = 8'h00;
    logic       sl = 1'b0;
    logic       sv = 1'b0;
    logic       sv0 = 1'b0;
    logic       rdy, en, busy, und;
    logic [3:0] txd;
    logic       rdy0, en0, busy0, und0;
    logic [3:0] txd0;

    always #5 clk = ~clk;

    mii_nibble_tx dut (
        .clkin(clk), .rst(rst), .s_data(sd), .s_valid(sv), .s_last(sl),
        .s_ready(rdy), .txen(en), .txd(txd), .busy(busy), .underrun(und)
    );

    mii_nibble_tx #(.MIN_BYTES(0)) dut0 (
        .clkin(clk), .rst(rst), .s_data(sd), .s_valid(sv0), .s_last(sl),
        .s_ready(rdy0), .txen(en0), .txd(txd0), .busy(busy0), .underrun(und0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  pay [0:2047];
    logic [3:0]  cap [0:4399];
    int          ncap, pre_low, gap_nz, rdy_n, rdy_pos, und_n, timeout;
    logic [31:0] last_fcs;

    typedef struct {
        bit sel;      // 0: default DUT, 1: MIN_BYTES=0 DUT
        int n;
        int pat;      // 0 incrementing, 1 ASCII "123...", 2 0xA5, 3 random
        int drop;     // transfer point at which s_valid is withheld (0 = never)
        bit keep;     // leave s_valid high after the frame
        bit gap;      // check the gap preceding this frame
        int exp_len;
        int exp_rdy;
        int exp_und;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input int n, input int len);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, (i < n) ? pay[i] : 8'h00};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic fill(input int n, input int pat);
        for (int i = 0; i < n; i++)
            case (pat)
                0: pay[i] = 8'(i);
                1: pay[i] = 8'(8'h31 + i);
                2: pay[i] = 8'hA5;
                default: pay[i] = 8'($urandom_range(0, 255));
            endcase
    endtask

    task automatic run_frame(input bit sel, input int n, input int drop_at, input bit keep);
        bit         started = 0, done = 0, xfer = 0, e, r, u, drop;
        logic [3:0] q;
        int         idx = 0;
        ncap = 0; pre_low = 0; gap_nz = 0; rdy_n = 0; rdy_pos = -1; und_n = 0; timeout = 0;
        sd = pay[0];
        sl = (n == 1);
        if (sel) sv0 = 1'b1; else sv = 1'b1;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(posedge clk); #1;
            if (xfer) idx++;
            e = sel ? en0 : en;
            q = sel ? txd0 : txd;
            r = sel ? rdy0 : rdy;
            u = sel ? und0 : und;
            if (u) und_n++;
            if (e) begin
                if (ncap < 4400) cap[ncap] = q;
                ncap++;
                started = 1;
            end else if (started) begin
                done = 1;
            end else begin
                pre_low++;
                if (q != 4'h0) gap_nz++;
            end
            if (r) begin
                rdy_n++;
                if (rdy_n == 1) rdy_pos = ncap - 1;
            end
            if (idx < n) begin
                sd = pay[idx];
                sl = (idx == n - 1);
            end
            drop = r && (rdy_n == drop_at);
            if (sel) sv0 = !drop; else sv = !drop;
            xfer = r && !drop;
        end
        if (!done) timeout = 1;
        if (!keep) begin
            sv  = 1'b0;
            sv0 = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input bit sel, input int n, input int exp_len,
                               input int drop_at, input int exp_rdy, input int exp_und,
                               input bit chk_gap);
        int          len = (!sel && n < 60) ? 60 : n;
        int          hdr_bad = 0, dat_bad = 0;
        logic [7:0]  b;
        logic [31:0] fcs_act = '0;
        chk({tag, ".timeout"}, timeout, 0);
        chk({tag, ".len"}, ncap, exp_len);
        for (int i = 0; i < 16; i++)
            if (cap[i] !== ((i == 15) ? 4'hD : 4'h5)) hdr_bad++;
        chk({tag, ".preamble_bad"}, hdr_bad, 0);
        chk({tag, ".ready_count"}, rdy_n, exp_rdy);
        chk({tag, ".ready_first_pos"}, rdy_pos, 15);
        chk({tag, ".underrun_pulses"}, und_n, exp_und);
        if (drop_at == 0) begin
            for (int i = 0; i < len; i++) begin
                b = (i < n) ? pay[i] : 8'h00;
                if (cap[16 + 2 * i] !== b[3:0] || cap[17 + 2 * i] !== b[7:4]) dat_bad++;
            end
            chk({tag, ".data_bad"}, dat_bad, 0);
            for (int k = 0; k < 8; k++) fcs_act[4 * k +: 4] = cap[16 + 2 * len + k];
            chk({tag, ".fcs"}, fcs_act, crc_model(n, len));
        end
        last_fcs = fcs_act;
        if (chk_gap) begin
            chk({tag, ".gap_cycles"}, pre_low + 1, 24);
            chk({tag, ".gap_txd_nonzero"}, gap_nz, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [8];
        tv[0] = '{0, 64, 0, 0, 0, 0, 152, 64, 0};
        tv[1] = '{1,  9, 1, 0, 0, 0,  42,  9, 0};
        tv[2] = '{0,  1, 2, 0, 0, 0, 144,  1, 0};
        tv[3] = '{0, 10, 0, 3, 1, 0,  20,  3, 1};
        tv[4] = '{0,  5, 0, 0, 0, 1, 144,  5, 0};
        tv[5] = '{0, 60, 3, 0, 0, 0, 144, 60, 0};
        tv[6] = '{0, 59, 3, 0, 0, 0, 144, 59, 0};
        tv[7] = '{0, 61, 3, 0, 0, 0, 146, 61, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.dut", {24'd0, en, txd, rdy, busy, und}, 0);
        chk("reset.dut0", {24'd0, en0, txd0, rdy0, busy0, und0}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle.busy", {31'd0, busy}, 0);

        for (int t = 0; t < 8; t++) begin
            fill(tv[t].n, tv[t].pat);
            run_frame(tv[t].sel, tv[t].n, tv[t].drop, tv[t].keep);
            check_frame($sformatf("vec%0d", t), tv[t].sel, tv[t].n, tv[t].exp_len,
                        tv[t].drop, tv[t].exp_rdy, tv[t].exp_und, tv[t].gap);
            if (tv[t].pat == 1) chk("vec_ascii.fcs_const", last_fcs, 32'hCBF43926);
        end

        for (int f = 0; f < 10; f++) begin
            fill(1300, 3);
            run_frame(0, 1300, 0, 1);
            check_frame($sformatf("b2b%0d", f), 0, 1300, 16 + 2600 + 8, 0, 1300, 0, f > 0);
        end

        // Reset pulse in the middle of the payload, then a fresh frame.
        sd = 8'h3C;
        sl = 1'b0;
        sv = 1'b1;
        for (int c = 0; c < 100 && !en; c++) begin
            @(posedge clk); #1;
        end
        repeat (24) @(posedge clk);
        #1;
        chk("rstmid.pre_txen_busy", {30'd0, en, busy}, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.after", {25'd0, en, txd, busy, und}, 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) pay[i] = 8'(8'h80 + i);
        run_frame(0, 12, 0, 0);
        check_frame("rstmid.frame", 0, 12, 144, 0, 12, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
